dct_serial_rx: RTL and testbench

//  Receive side of the DCT core's serial result stream (oSDAT/oSVAL of user_proj_example).

---
 rtl/dct_pkg.sv | 25 ++
 rtl/dct_sync_fifo.sv | 49 ++++
 rtl/dct_serial_rx.sv | 95 +++++++++
 tb/tb_dct_serial_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants, types and size decode for the DCT serial receive path
package dct_pkg;

    localparam int IDX_W  = 5;
    localparam int COEF_W = 16;

    localparam logic [2:0] SIZE_4  = 3'd0;
    localparam logic [2:0] SIZE_8  = 3'd1;
    localparam logic [2:0] SIZE_16 = 3'd2;
    localparam logic [2:0] SIZE_32 = 3'd3;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [COEF_W-1:0] coef_t;

    // Codes 3..7 all select the full 32-coefficient block.
    function automatic logic [5:0] size_to_n(input logic [2:0] code);
        case (code)
            SIZE_4:  return 6'd4;
            SIZE_8:  return 6'd8;
            SIZE_16: return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/dct_sync_fifo.sv
// rtl/dct_sync_fifo.sv - first-word-fall-through FIFO; accepts a push when full if a pop happens in the same cycle
module dct_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/dct_serial_rx.sv
// rtl/dct_serial_rx.sv - deserializes the DCT core result stream into indexed words behind a FIFO
module dct_serial_rx
    import dct_pkg::*;
#(
    parameter int W         = 16,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iSDAT,
    input  logic         iSVAL,
    input  logic [2:0]   iSize,
    output logic [W-1:0] oData,
    output logic [4:0]   oIdx,
    output logic         oLast,
    output logic         oValid,
    input  logic         iReady,
    output logic         oOverflow,
    input  logic         iClrErr,
    output logic         oBusy
);

    localparam int CNT_W = $clog2(W);
    localparam int ENT_W = W + IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    logic [W-1:0]     shift_q;
    logic [W-1:0]     shift_next;
    logic [CNT_W-1:0] bit_cnt;
    idx_t             idx;
    logic [5:0]       n_lat;
    logic [5:0]       n_eff;
    idx_t             last_idx;
    logic             block_start;
    logic             is_last;
    logic             word_done;
    logic             push_ok;
    logic             fifo_empty;
    logic [ENT_W-1:0] head;

    assign block_start = (bit_cnt == '0) && (idx == '0);
    assign word_done   = iSVAL && (bit_cnt == LAST_BIT);

    // The size in force for the word being assembled; a fresh block samples iSize directly.
    always_comb begin
        shift_next = MSB_FIRST ? {shift_q[W-2:0], iSDAT} : {iSDAT, shift_q[W-1:1]};
        n_eff      = block_start ? size_to_n(iSize) : n_lat;
        last_idx   = IDX_W'(n_eff - 6'd1);
        is_last    = (idx == last_idx);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            idx       <= '0;
            n_lat     <= 6'd32;
            oOverflow <= 1'b0;
        end else begin
            if (iSVAL) begin
                shift_q <= shift_next;
                if (block_start) n_lat <= size_to_n(iSize);
                if (word_done) begin
                    bit_cnt <= '0;
                    // Index advances even on a dropped word to keep block alignment.
                    idx     <= is_last ? '0 : idx + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (word_done && !push_ok) oOverflow <= 1'b1;
            else if (iClrErr)          oOverflow <= 1'b0;
        end
    end

    dct_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (iClk),
        .rst       (iRst),
        .push      (word_done),
        .push_data ({shift_next, idx, is_last}),
        .push_ok   (push_ok),
        .pop       (iReady),
        .head      (head),
        .empty     (fifo_empty)
    );

    assign oValid               = !fifo_empty;
    assign {oData, oIdx, oLast} = head;
    assign oBusy                = (bit_cnt != '0) || (idx != '0);

endmodule

// File: tb/tb_dct_serial_rx.sv
// tb/tb_dct_serial_rx.sv - scoreboard bench for dct_serial_rx, MSB-first and LSB-first builds side by side
module tb_dct_serial_rx;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdat_m, sdat_l, sval, ready, clr;
    logic [2:0]  size;

    logic [W-1:0] d_m, d_l;
    logic [4:0]   i_m, i_l;
    logic         l_m, l_l, v_m, v_l, ovf_m, ovf_l, busy_m, busy_l;

    always #5 clk = ~clk;

    dct_serial_rx #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .iClk(clk), .iRst(rst), .iSDAT(sdat_m), .iSVAL(sval), .iSize(size),
        .oData(d_m), .oIdx(i_m), .oLast(l_m), .oValid(v_m), .iReady(ready),
        .oOverflow(ovf_m), .iClrErr(clr), .oBusy(busy_m)
    );

    dct_serial_rx #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .iClk(clk), .iRst(rst), .iSDAT(sdat_l), .iSVAL(sval), .iSize(size),
        .oData(d_l), .oIdx(i_l), .oLast(l_l), .oValid(v_l), .iReady(ready),
        .oOverflow(ovf_l), .iClrErr(clr), .oBusy(busy_l)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [4:0]   idx;
        logic         last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   m_idx    = 0;
    int   m_n      = 32;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input logic [2:0] s);
        if (s == 3'd0) return 4;
        if (s == 3'd1) return 8;
        if (s == 3'd2) return 16;
        return 32;
    endfunction

    exp_t e;
    always @(negedge clk) begin
        if (!rst && ready && v_m) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("data", d_m, e.data);
                check("idx", i_m, e.idx);
                check("last", l_m, e.last);
                check("lsb_valid", v_l, 1);
                check("lsb_data", d_l, e.data);
                check("lsb_idx", i_l, e.idx);
                check("lsb_last", l_l, e.last);
            end
        end else if (!rst && ready && v_l) begin
            check("lsb_spurious", 32'd1, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sval = 1'b0;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input int max_gap);
        logic last;
        if (m_idx == 0) m_n = n_of(size);
        for (int k = 0; k < W; k++) begin
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
            @(posedge clk); #1;
            sval   = 1'b1;
            sdat_m = w[W-1-k];
            sdat_l = w[k];
        end
        last = (m_idx == m_n - 1);
        if (!(!ready && q.size() >= DEPTH))
            q.push_back({w, 5'(m_idx), last});
        m_idx = last ? 0 : m_idx + 1;
    endtask

    task automatic check_ovf(input string tag, input logic exp);
        check({tag, "_msb"}, ovf_m, exp);
        check({tag, "_lsb"}, ovf_l, exp);
    endtask

    logic [W-1:0] words [4];
    logic [W-1:0] partial;

    initial begin
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001; words[3] = 16'h8000;
        rst = 1'b1; sval = 1'b0; sdat_m = 1'b0; sdat_l = 1'b0;
        size = 3'd0; ready = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state and idle
        @(negedge clk);
        check("rst_valid", v_m, 0);
        check("rst_ovf", ovf_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_idx", i_m, 0);
        check("rst_data", d_m, 0);
        check("rst_last", l_m, 0);
        idle(40);
        check("idle_valid", v_m, 0);
        check("idle_busy", busy_l, 0);

        // 2: continuous stream, N=4, latency of first word
        send_word(words[0], 0);
        @(negedge clk);
        check("lat_pre", v_m, 0);
        @(posedge clk); #1 sval = 1'b0;
        @(negedge clk);
        check("lat_post", v_m, 1);
        for (int i = 1; i < 4; i++) send_word(words[i], 0);
        idle(4);
        check("t2_drained", q.size(), 0);

        // 3: same words with random gaps
        for (int i = 0; i < 4; i++) send_word(words[i], 5);
        idle(4);
        check("t3_drained", q.size(), 0);
        check("t3_busy", busy_m, 0);

        // 4: overflow with consumer stalled, N=8
        size  = 3'd1;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(16'h1000 + 16'(i), 0);
        idle(2);
        check("t4_held", v_m, 1);
        check_ovf("ovf_set", 1'b1);
        ready = 1'b1;
        idle(8);
        check("t4_drained", q.size(), 0);
        send_word(16'h5A5A, 0);
        idle(3);
        check_ovf("ovf_sticky", 1'b1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check_ovf("ovf_clr", 1'b0);
        send_word(16'h0F0F, 0);
        send_word(16'hF0F0, 0);
        idle(3);
        check("t4_busy", busy_m, 0);

        // 5: size change mid-block takes effect at next block
        size = 3'd3;
        for (int i = 0; i < 11; i++) send_word(16'($urandom), 0);
        size = 3'd0;
        idle(1);
        check("t5_busy_mid", busy_m, 1);
        for (int i = 11; i < 32 + 4; i++) send_word(16'($urandom), 0);
        idle(4);
        check("t5_busy_end", busy_m, 0);
        check("t5_drained", q.size(), 0);

        // 6: reset in the middle of a word
        size = 3'd2;
        send_word(16'hC3C3, 0);
        send_word(16'h3C3C, 0);
        partial = 16'hDEAD;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            sval = 1'b1; sdat_m = partial[W-1-k]; sdat_l = partial[k];
        end
        check("t6_pre_rst_q", q.size(), 0);
        @(posedge clk); #1 rst = 1'b1; sval = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        m_idx = 0;
        m_n   = 32;
        @(negedge clk);
        check("t6_busy_msb", busy_m, 0);
        check("t6_busy_lsb", busy_l, 0);
        check("t6_valid", v_m, 0);
        send_word(16'hBEEF, 0);
        idle(4);
        check("t6_drained", q.size(), 0);

        idle(5);
        check("final_ovf", ovf_m, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
